// File: rtl/gelato_inst_buffer.sv
// gelato_inst_buffer: per-warp instruction FIFOs between decode and issue, round-robin head selection
//   clk, rst_n              clock, asynchronous active-low reset
//   rdy                     global enable; low freezes all state and blocks issue
//   inst_decoded_data       decode handshake (valid, inst); target warp is inst.warp_num
//   flush_valid/_warp_num   clear one warp's FIFO
//   warp_full, warp_empty   per-warp status from the registered counts
//   issue_valid/_ready      issue handshake; head is first-word-fall-through
//   issue_inst/_warp_num    head instruction of the selected warp
//   overflow                sticky: a write was dropped because its FIFO was full
package gelato_pkg;
    localparam int GELATO_NUM_WARPS = 4;
    localparam int GELATO_WARP_W = $clog2(GELATO_NUM_WARPS);
    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              raw;
        logic [GELATO_WARP_W-1:0] warp_num;
    } inst_t;
endpackage

interface gelato_idecode_ibuffer_if;
    logic              valid;
    gelato_pkg::inst_t inst;
    modport master(output valid, inst);
    modport slave(input valid, inst);
endinterface

module gelato_inst_buffer #(
    parameter int NUM_WARPS = gelato_pkg::GELATO_NUM_WARPS,
    parameter int DEPTH = 4,
    localparam int WARP_W = $clog2(NUM_WARPS),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    gelato_idecode_ibuffer_if.slave  inst_decoded_data,
    input  logic                     flush_valid,
    input  logic [WARP_W-1:0]        flush_warp_num,
    output logic [NUM_WARPS-1:0]     warp_full,
    output logic [NUM_WARPS-1:0]     warp_empty,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output gelato_pkg::inst_t        issue_inst,
    output logic [WARP_W-1:0]        issue_warp_num,
    output logic                     overflow
);
    gelato_pkg::inst_t               mem_q [NUM_WARPS][DEPTH];
    gelato_pkg::inst_t               mem_d [NUM_WARPS][DEPTH];
    logic [NUM_WARPS-1:0][CNT_W-1:0] count_q, count_d;
    logic [NUM_WARPS-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [WARP_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic                            overflow_q, overflow_d;
    logic [NUM_WARPS-1:0]            elig, flush_mask;
    logic [WARP_W-1:0]               sel, wr_warp;
    logic                            found, pop, wr_req, wr_en;
    gelato_pkg::inst_t               wr_inst;

    assign wr_inst = inst_decoded_data.inst;
    assign wr_warp = wr_inst.warp_num;

    always_comb begin
        warp_full = '0;
        warp_empty = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            warp_full[i] = count_q[i] == CNT_W'(DEPTH);
            warp_empty[i] = count_q[i] == '0;
        end
    end

    // A warp being flushed this cycle is never a candidate, even if it holds entries.
    always_comb begin
        flush_mask = flush_valid ? (NUM_WARPS'(1) << flush_warp_num) : '0;
        elig = ~warp_empty & ~flush_mask;
        sel = rr_ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!found && elig[rr_ptr_q + WARP_W'(i)]) begin
                sel = rr_ptr_q + WARP_W'(i);
                found = 1'b1;
            end
        end
    end

    assign issue_valid = rdy && |elig;
    assign issue_warp_num = sel;
    assign issue_inst = mem_q[sel][rd_ptr_q[sel]];
    assign overflow = overflow_q;
    assign pop = issue_valid && issue_ready;
    // A write racing a flush of its own warp is silently discarded, not counted as overflow.
    assign wr_req = rdy && inst_decoded_data.valid && !(flush_valid && flush_warp_num == wr_warp);
    // A full warp still accepts a write when its head leaves in the same cycle.
    assign wr_en = wr_req && (!warp_full[wr_warp] || (pop && sel == wr_warp));

    always_comb begin
        mem_d = mem_q;
        count_d = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rr_ptr_d = pop ? sel + WARP_W'(1) : rr_ptr_q;
        overflow_d = overflow_q | (wr_req && !wr_en);
        if (wr_en)
            mem_d[wr_warp][wr_ptr_q[wr_warp]] = wr_inst;
        for (int i = 0; i < NUM_WARPS; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(wr_en && wr_warp == WARP_W'(i));
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop && sel == WARP_W'(i));
            count_d[i] = count_q[i] + CNT_W'(wr_en && wr_warp == WARP_W'(i))
                                    - CNT_W'(pop && sel == WARP_W'(i));
            if (rdy && flush_valid && flush_warp_num == WARP_W'(i)) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_ptr_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_ptr_q <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: counts and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_gelato_inst_buffer.sv
// tb_gelato_inst_buffer: directed scoreboard bench for gelato_inst_buffer
module tb_gelato_inst_buffer;
    import gelato_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        flush_valid = 1'b0;
    logic [1:0]  flush_warp_num = '0;
    logic [3:0]  warp_full, warp_empty;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    inst_t       issue_inst;
    logic [1:0]  issue_warp_num;
    logic        overflow;
    int          checks = 0;
    int          failures = 0;
    logic [33:0] exp_q[$];

    gelato_idecode_ibuffer_if dec_if();

    gelato_inst_buffer dut (
        .clk(clk),
        .rst_n(rst_n),
        .rdy(rdy),
        .inst_decoded_data(dec_if),
        .flush_valid(flush_valid),
        .flush_warp_num(flush_warp_num),
        .warp_full(warp_full),
        .warp_empty(warp_empty),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_inst(issue_inst),
        .issue_warp_num(issue_warp_num),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue must match the oldest expected {warp, pc}.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got warp %0d pc %0h expected none", issue_warp_num, issue_inst.pc);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("issue", {issue_warp_num, issue_inst.pc}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] w, input logic [31:0] pc);
        dec_if.valid = 1'b1;
        dec_if.inst.pc = pc;
        dec_if.inst.raw = ~pc;
        dec_if.inst.warp_num = w;
    endtask

    task automatic idle();
        dec_if.valid = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [1:0] w, input logic [31:0] pc);
        exp_q.push_back({w, pc});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        issue_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        step();
        chk("drain_left", 64'(exp_q.size()), 0);
    endtask

    initial begin
        dec_if.valid = 1'b0;
        dec_if.inst = '0;
        do_reset();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_warp_empty", warp_empty, 4'hF);
        chk("rst_warp_full", warp_full, 0);
        chk("rst_overflow", overflow, 0);

        issue_ready = 1'b1;
        expect_issue(2, 32'h00);
        expect_issue(2, 32'h04);
        expect_issue(2, 32'h08);
        put(2, 32'h00);
        #1 chk("t1_no_bypass", issue_valid, 0);
        step();
        put(2, 32'h04);
        #1 chk("t1_valid_next", issue_valid, 1);
        step();
        put(2, 32'h08);
        step();
        idle();
        step();
        step();
        chk("t1_empty2", warp_empty[2], 1);
        chk("t1_drained", 64'(exp_q.size()), 0);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            put(0, 32'h100 + 32'(4 * i)); step();
            put(1, 32'h200 + 32'(4 * i)); step();
            put(3, 32'h300 + 32'(4 * i)); step();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            expect_issue(0, 32'h100 + 32'(4 * i));
            expect_issue(1, 32'h200 + 32'(4 * i));
            expect_issue(3, 32'h300 + 32'(4 * i));
        end
        issue_ready = 1'b1;
        drain();
        issue_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            put(1, 32'h400 + 32'(4 * i));
            expect_issue(1, 32'h400 + 32'(4 * i));
            step();
        end
        idle();
        #1 chk("t3_full", warp_full[1], 1);
        chk("t3_no_ovf_yet", overflow, 0);
        put(1, 32'h410);
        step();
        idle();
        #1 chk("t3_ovf", overflow, 1);
        chk("t3_still_full", warp_full[1], 1);
        put(1, 32'h414);
        expect_issue(1, 32'h414);
        issue_ready = 1'b1;
        step();
        idle();
        issue_ready = 1'b0;
        #1 chk("t3_full_after_swap", warp_full[1], 1);
        issue_ready = 1'b1;
        drain();
        issue_ready = 1'b0;

        do_reset();
        put(0, 32'h500); step();
        put(0, 32'h504); step();
        put(0, 32'h508); step();
        idle();
        flush_valid = 1'b1;
        flush_warp_num = 2'd0;
        put(0, 32'h5FC);
        issue_ready = 1'b1;
        #1 chk("t4_masked", issue_valid, 0);
        step();
        idle();
        #1 chk("t4_empty0", warp_empty[0], 1);
        chk("t4_ovf_unchanged", overflow, 0);
        repeat (4) step();
        chk("t4_nothing_left", issue_valid, 0);
        issue_ready = 1'b0;

        put(3, 32'h600); expect_issue(3, 32'h600); step();
        put(3, 32'h604); expect_issue(3, 32'h604); step();
        rdy = 1'b0;
        put(3, 32'h6F0);
        flush_valid = 1'b1;
        flush_warp_num = 2'd3;
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_rdy_low_iv", issue_valid, 0);
            chk("t5_rdy_low_empty", warp_empty, 4'b0111);
            step();
        end
        rdy = 1'b1;
        idle();
        #1 chk("t5_kept", warp_empty[3], 0);
        drain();
        chk("t5_all_empty", warp_empty, 4'hF);
        issue_ready = 1'b0;

        put(1, 32'h700); step();
        put(2, 32'h704); step();
        idle();
        #1 chk("t6_pre_iv", issue_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_iv", issue_valid, 0);
        chk("t6_async_empty", warp_empty, 4'hF);
        chk("t6_async_full", warp_full, 0);
        step();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gelato_inst_buffer.md
# gelato_inst_buffer

Per-warp instruction buffer between the instruction decode unit and the warp scheduler/issue stage. Accepts one decoded instruction per cycle on the `gelato_idecode_ibuffer_if` slave side, stores it in a small FIFO owned by the instruction's warp, and presents one head instruction per cycle to issue, choosing among non-empty warps round-robin. Exposes per-warp full status to fetch, and a per-warp flush for control-flow redirects.

## Interface
- `NUM_WARPS`, 4: number of warps, power of two ≥2; `WARP_W = $clog2(NUM_WARPS)`
- `DEPTH`, 4: entries per warp FIFO, power of two ≥2; `CNT_W = $clog2(DEPTH+1)`
- `clk` input 1: clock
- `rst_n` input 1: reset, asynchronous, active-low
- `rdy` input 1: global enable; when low, no state changes
- `inst_decoded_data` slave modport of `gelato_idecode_ibuffer_if`: `valid` (1), `inst` (`inst_t`); the target warp is `inst.warp_num`
- `flush_valid` input 1: clear one warp's FIFO
- `flush_warp_num` input WARP_W: warp to flush
- `warp_full` output NUM_WARPS: bit w = FIFO w holds DEPTH entries
- `warp_empty` output NUM_WARPS: bit w = FIFO w holds 0 entries
- `issue_valid` output 1: head instruction presented
- `issue_ready` input 1: issue stage accepts
- `issue_inst` output `inst_t`: head instruction of the selected warp
- `issue_warp_num` output WARP_W: selected warp
- `overflow` output 1: sticky; set when a write is dropped because the FIFO is full

## Operation
- Per warp: storage[DEPTH], rd_ptr/wr_ptr (`$clog2(DEPTH)` bits, natural wrap), count (CNT_W bits).
- Write (w = `inst.warp_num`) takes effect when `rdy && valid`, and either count[w] < DEPTH or warp w pops in the same cycle. Effects: storage[w][wr_ptr] <= inst; wr_ptr++.
- Write to a full warp with no same-cycle pop: dropped, `overflow` <= 1. `overflow` clears only on reset.
- Selection (combinational): eligible = ~warp_empty, masked by `flush_valid`-decoded warp. Pick the first eligible warp scanning from rr_ptr upward, wrapping modulo NUM_WARPS.
- `issue_valid` = rdy && any eligible. `issue_inst` = head of the selected warp. `issue_warp_num` = selected warp. When `issue_valid` = 0, `issue_inst` and `issue_warp_num` are don't-care.
- Pop: `issue_valid && issue_ready`. Effects: rd_ptr[sel]++, rr_ptr <= sel+1 (wrap).
- count update per warp: +1 write only, −1 pop only, unchanged for both or neither.
- Flush (`rdy && flush_valid`): warp f count/rd_ptr/wr_ptr <= 0. A same-cycle write to f is dropped without setting `overflow`. Warp f cannot be selected that cycle. Other warps are unaffected.
- `warp_full`/`warp_empty` derive from registered count only.

## Timing
- Reset: all counts, pointers, rr_ptr = 0. `overflow` = 0, `warp_full` = 0, `warp_empty` = all ones, `issue_valid` = 0.
- Write-to-issue latency is 1 cycle: an entry written in cycle N can first issue in cycle N+1. There is no same-cycle bypass, so an empty warp written in cycle N is not eligible in cycle N.
- Issue is first-word-fall-through: the head is visible combinationally; the pop takes effect on the clock edge.
- Full warp with a same-cycle pop and write: both are performed, and count stays at DEPTH.
- `rdy` low: registers hold, `issue_valid` = 0, and writes and flushes are ignored (decode holds its output under `!rdy`).
- Reset asserted mid-operation: all contents are discarded immediately (asynchronous). Outputs return to their reset values without waiting for a clock.
- Fetch must throttle on `warp_full`, accounting for its fetch-to-decode pipeline depth. `overflow` is a verification/debug flag only.

## Test plan
- Reset, then write 3 instructions to warp 2 (pc 0x00, 0x04, 0x08) with `issue_ready` = 1. Required: `issue_valid` rises the cycle after the first write, and the pcs issue in order 0x00, 0x04, 0x08 with `issue_warp_num` = 2. Afterwards `warp_empty[2]` = 1.
- Fill warps 0, 1, 3 with 2 entries each, then hold `issue_ready` = 1. Required issue warp order: 0, 1, 3, 0, 1, 3.
- Fill warp 1 to DEPTH = 4, so `warp_full[1]` = 1. Write a 5th with `issue_ready` = 0: it is dropped and `overflow` = 1. Then write a 6th in a cycle where warp 1 pops: it is accepted, count stays 4, and the issue order is preserved.
- Warp 0 holds 3 entries. Assert flush of warp 0 together with a write to warp 0. Required: `issue_valid` = 0 that cycle, `warp_empty[0]` = 1 the next cycle, the written entry never issues, and `overflow` is unchanged.
- Hold `rdy` = 0 for 3 cycles while `valid`, `flush_valid`, and `issue_ready` are asserted. Required: `issue_valid` = 0 and counts unchanged. After `rdy` returns to 1, operation resumes from the same state.
- Drop `rst_n` mid-traffic between clock edges. Required: `issue_valid` = 0 and `warp_empty` = 4'b1111 before the next edge.
